id_ex_stage_reg: RTL and testbench

//  ID->EX pipeline register of the ARM core. Captures decoded operands and control from the ID stage each clock.

---
 rtl/id_ex_stage_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: captures decoded operands and control, with freeze (hold) and flush (bubble).
// Optional macro FORWARDING_EN adds src1/src2 register addresses for the EX forwarding unit.
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     PC_in,
    input  logic [DATA_W-1:0]     Val_Rn_in,
    input  logic [DATA_W-1:0]     Val_Rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           Shift_operand_in,
    input  logic [23:0]           signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    input  logic [3:0]            EXE_CMD_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic                  WB_EN_in,
    input  logic                  B_in,
    input  logic                  S_in,
    input  logic [3:0]            SR_in,
`ifdef FORWARDING_EN
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
`endif
    output logic                  valid_out,
    output logic [DATA_W-1:0]     PC_out,
    output logic [DATA_W-1:0]     Val_Rn_out,
    output logic [DATA_W-1:0]     Val_Rm_out,
    output logic                  imm_out,
    output logic [11:0]           Shift_operand_out,
    output logic [23:0]           signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] Dest_out,
    output logic [3:0]            EXE_CMD_out,
    output logic                  MEM_R_EN_out,
    output logic                  MEM_W_EN_out,
    output logic                  WB_EN_out,
    output logic                  B_out,
    output logic                  S_out,
    output logic [3:0]            SR_out,
    output logic                  is_ldr_or_str
);

    // Datapath fields: hold on freeze, zero on flush, otherwise capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_out            <= '0;
            Val_Rn_out        <= '0;
            Val_Rm_out        <= '0;
            imm_out           <= 1'b0;
            Shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            Dest_out          <= '0;
            EXE_CMD_out       <= '0;
            SR_out            <= '0;
        end else if (!freeze) begin
            if (flush) begin
                PC_out            <= '0;
                Val_Rn_out        <= '0;
                Val_Rm_out        <= '0;
                imm_out           <= 1'b0;
                Shift_operand_out <= '0;
                signed_imm_24_out <= '0;
                Dest_out          <= '0;
                EXE_CMD_out       <= '0;
                SR_out            <= '0;
            end else begin
                PC_out            <= PC_in;
                Val_Rn_out        <= Val_Rn_in;
                Val_Rm_out        <= Val_Rm_in;
                imm_out           <= imm_in;
                Shift_operand_out <= Shift_operand_in;
                signed_imm_24_out <= signed_imm_24_in;
                Dest_out          <= Dest_in;
                EXE_CMD_out       <= EXE_CMD_in;
                SR_out            <= SR_in;
            end
        end
    end

    // Control fields: a slot without a real instruction must never write, access memory or branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            WB_EN_out    <= 1'b0;
            B_out        <= 1'b0;
            S_out        <= 1'b0;
        end else if (!freeze) begin
            if (flush) begin
                valid_out    <= 1'b0;
                MEM_R_EN_out <= 1'b0;
                MEM_W_EN_out <= 1'b0;
                WB_EN_out    <= 1'b0;
                B_out        <= 1'b0;
                S_out        <= 1'b0;
            end else begin
                valid_out    <= valid_in;
                MEM_R_EN_out <= MEM_R_EN_in & valid_in;
                MEM_W_EN_out <= MEM_W_EN_in & valid_in;
                WB_EN_out    <= WB_EN_in & valid_in;
                B_out        <= B_in & valid_in;
                S_out        <= S_in & valid_in;
            end
        end
    end

`ifdef FORWARDING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1_out <= '0;
            src2_out <= '0;
        end else if (!freeze) begin
            if (flush) begin
                src1_out <= '0;
                src2_out <= '0;
            end else begin
                src1_out <= src1_in;
                src2_out <= src2_in;
            end
        end
    end
`endif

    assign is_ldr_or_str = MEM_R_EN_out | MEM_W_EN_out;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver queues expected slot contents, a negedge monitor checks them.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic [3:0]  sr;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  freeze = 1'b0;
    logic  flush = 1'b0;
    slot_t din = '0;
    slot_t dout;
    slot_t model = '0;
    logic  is_ls;
    slot_t expq[$];
    int    checks = 0;
    int    failures = 0;
    logic [3:0] src1_o, src2_o;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(din.valid), .PC_in(din.pc), .Val_Rn_in(din.rn), .Val_Rm_in(din.rm),
        .imm_in(din.imm), .Shift_operand_in(din.shop), .signed_imm_24_in(din.simm),
        .Dest_in(din.dest), .EXE_CMD_in(din.cmd), .MEM_R_EN_in(din.mr), .MEM_W_EN_in(din.mw),
        .WB_EN_in(din.wb), .B_in(din.b), .S_in(din.s), .SR_in(din.sr),
`ifdef FORWARDING_EN
        .src1_in(din.src1), .src2_in(din.src2), .src1_out(src1_o), .src2_out(src2_o),
`endif
        .valid_out(dout.valid), .PC_out(dout.pc), .Val_Rn_out(dout.rn), .Val_Rm_out(dout.rm),
        .imm_out(dout.imm), .Shift_operand_out(dout.shop), .signed_imm_24_out(dout.simm),
        .Dest_out(dout.dest), .EXE_CMD_out(dout.cmd), .MEM_R_EN_out(dout.mr),
        .MEM_W_EN_out(dout.mw), .WB_EN_out(dout.wb), .B_out(dout.b), .S_out(dout.s),
        .SR_out(dout.sr), .is_ldr_or_str(is_ls)
    );

`ifndef FORWARDING_EN
    assign src1_o = 4'd0;
    assign src2_o = 4'd0;
`endif
    assign dout.src1 = src1_o;
    assign dout.src2 = src2_o;

    function automatic slot_t strip_src(input slot_t s);
        slot_t r = s;
`ifndef FORWARDING_EN
        r.src1 = 4'd0;
        r.src2 = 4'd0;
`endif
        return r;
    endfunction

    task automatic check_slot(input string name, input slot_t exp);
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, dout, exp);
        end
        checks++;
        if (is_ls !== (exp.mr | exp.mw)) begin
            failures++;
            $display("FAIL %s_is_ldr_or_str: got %b expected %b", name, is_ls, exp.mr | exp.mw);
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare the registered slot.
    always @(negedge clk) begin
        if (expq.size() != 0) check_slot("slot", expq.pop_front());
    end

    // One clock: inputs already driven; update reference state, push it at the edge.
    task automatic step(input logic fz, input logic fl, input slot_t v);
        slot_t n;
        freeze = fz;
        flush  = fl;
        din    = v;
        if (fz) n = model;
        else if (fl) n = '0;
        else begin
            n = strip_src(v);
            if (!v.valid) {n.mr, n.mw, n.wb, n.b, n.s} = 5'b0;
        end
        @(posedge clk);
        model = n;
        expq.push_back(n);
        @(negedge clk);
        #1;
    endtask

    function automatic slot_t vec(input logic vld, input logic [31:0] pc, input logic [31:0] rn,
                                  input logic [31:0] rm, input logic imm, input logic [11:0] shop,
                                  input logic [3:0] dest, input logic [4:0] ctl,
                                  input logic [3:0] s1, input logic [3:0] s2);
        slot_t r;
        r = '0;
        r.valid = vld; r.pc = pc; r.rn = rn; r.rm = rm; r.imm = imm; r.shop = shop;
        r.simm = 24'hA5_1234 ^ pc[23:0]; r.dest = dest; r.cmd = rm[3:0] ^ 4'h6;
        {r.mr, r.mw, r.wb, r.b, r.s} = ctl; r.sr = 4'b1010; r.src1 = s1; r.src2 = s2;
        return r;
    endfunction

    initial begin
        slot_t v;
        slot_t r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_slot("reset_state", '0);
        rst = 1'b0;
        #1;
        // Operand capture, no memory access
        v = vec(1'b1, 32'h0000_0104, 32'h1234_5678, 32'hF000_000F, 1'b0, 12'h063, 4'd2, 5'b00100, 4'd3, 4'd7);
        step(1'b0, 1'b0, v);
        // Load instruction, then freeze while inputs change
        v = vec(1'b1, 32'h0000_0108, 32'h0000_1000, 32'h0, 1'b0, 12'h004, 4'd4, 5'b10100, 4'd1, 4'd2);
        step(1'b0, 1'b0, v);
        for (int i = 0; i < 3; i++) begin
            r = vec(1'b1, $urandom, $urandom, $urandom, 1'b1, 12'hFFF, 4'(i), 5'b01011, 4'd9, 4'd9);
            step(1'b1, (i == 1), r);
        end
        // Flush bubble over a writeback branch
        v = vec(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h5, 1'b1, 12'h0AB, 4'd5, 5'b00110, 4'd6, 4'd8);
        step(1'b0, 1'b1, v);
        // Invalid slot: control gated off, datapath still captured
        v = vec(1'b0, 32'h0000_0300, 32'hCAFE_0000, 32'h7, 1'b1, 12'h555, 4'd9, 5'b11111, 4'd10, 4'd11);
        step(1'b0, 1'b0, v);
        // Full slot, freeze+flush holds it, then flush alone bubbles; back-to-back flush
        v = vec(1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 12'hFFF, 4'd15, 5'b01111, 4'd15, 4'd14);
        step(1'b0, 1'b0, v);
        step(1'b1, 1'b1, vec(1'b1, 32'h1, 32'h2, 32'h3, 1'b0, 12'h1, 4'd1, 5'b11111, 4'd1, 4'd1));
        step(1'b0, 1'b1, v);
        step(1'b0, 1'b1, v);
        // Reload then asynchronous reset mid-cycle
        v = vec(1'b1, 32'h0000_0400, 32'h1111_1111, 32'h2222_2222, 1'b0, 12'h321, 4'd7, 5'b01101, 4'd5, 4'd6);
        step(1'b0, 1'b0, v);
        step(1'b0, 1'b0, vec(1'b1, 32'h0000_0404, 32'h3, 32'h4, 1'b1, 12'h010, 4'd3, 5'b10101, 4'd2, 4'd4));
        #2;
        rst = 1'b1;
        #1;
        check_slot("async_reset", '0);
        rst = 1'b0;
        model = '0;
        #1;
        step(1'b1, 1'b0, v);
        step(1'b0, 1'b0, v);
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
